// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, redirect squashes,
// memory-wait freeze with timeout, sticky halt and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       IFID_rs,
    input  logic [2:0]       IFID_rt,
    input  logic             IFID_rs_used,
    input  logic             IFID_rt_used,
    input  logic             IDEX_MemToReg,
    input  logic             IDEX_RegWrite,
    input  logic [2:0]       IDEX_WriteRegSel,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    input  logic             halt_req,
    output logic             pc_enable,
    output logic             IFID_enable,
    output logic             IDEX_enable,
    output logic             EXMEM_enable,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic [16:0]      wait_nx;
    logic             load_use;
    logic             stall_inc;
    logic             flush_inc;

    assign load_use = IDEX_MemToReg & IDEX_RegWrite &
                      ((IFID_rs_used & (IFID_rs == IDEX_WriteRegSel)) |
                       (IFID_rt_used & (IFID_rt == IDEX_WriteRegSel)));

    assign wait_nx = {1'b0, wait_q} + 17'd1;

    // Halt cycles freeze the pipe but are not counted as stalls.
    assign stall_inc = ~pc_enable & (state_q != HALT);
    assign flush_inc = IFID_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            if (stall_inc && !(&stall_q)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && !(&flush_q)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            RUN: begin
                if (dmem_busy) begin
                    state_d = MEM_WAIT;
                    wait_d  = 16'd1;
                end else if (halt_req) begin
                    state_d = HALT;
                end
            end
            MEM_WAIT: begin
                if (dmem_busy) begin
                    if (wait_nx >= 17'(TIMEOUT)) begin
                        state_d = HALT;
                        tmo_d   = 1'b1;
                    end else begin
                        wait_d = wait_nx[15:0];
                    end
                end else begin
                    state_d = halt_req ? HALT : RUN;
                    wait_d  = '0;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // MEM_WAIT with busy low falls through to the RUN priority chain.
    always_comb begin
        pc_enable    = 1'b1;
        IFID_enable  = 1'b1;
        IDEX_enable  = 1'b1;
        EXMEM_enable = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_flush   = 1'b0;
        if (rst) begin
            if ((state_q == HALT) || dmem_busy) begin
                pc_enable    = 1'b0;
                IFID_enable  = 1'b0;
                IDEX_enable  = 1'b0;
                EXMEM_enable = 1'b0;
            end else if (ex_redirect) begin
                IFID_flush = 1'b1;
                IDEX_flush = 1'b1;
            end else if (load_use) begin
                pc_enable   = 1'b0;
                IFID_enable = 1'b0;
                IDEX_flush  = 1'b1;
            end
        end
    end

    assign halted      = (state_q == HALT);
    assign timeout_err = tmo_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

endmodule
